// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on an inferred RAM array: registered status flags,
// programmable almost-full/almost-empty thresholds, sticky error flags and flush.
module sync_fifo_ram #(
    parameter int MEM_WIDTH    = 32,
    parameter int MEM_DEPTH    = 8,
    parameter int ADDRESS_SIZE = 3,
    parameter int AF_LEVEL     = 6,
    parameter int AE_LEVEL     = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    w_en,
    input  logic [MEM_WIDTH-1:0]    w_data,
    input  logic                    r_en,
    input  logic                    err_clr,
    output logic [MEM_WIDTH-1:0]    r_data,
    output logic                    r_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDRESS_SIZE-1:0] PTR_ONE   = ADDRESS_SIZE'(1);
    localparam logic [ADDRESS_SIZE:0]   CNT_ONE   = (ADDRESS_SIZE + 1)'(1);
    localparam logic [ADDRESS_SIZE:0]   CNT_FULL  = (ADDRESS_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDRESS_SIZE:0]   CNT_AF    = (ADDRESS_SIZE + 1)'(AF_LEVEL);
    localparam logic [ADDRESS_SIZE:0]   CNT_AE    = (ADDRESS_SIZE + 1)'(AE_LEVEL);

    if ((2 ** ADDRESS_SIZE) < MEM_DEPTH || MEM_DEPTH < 2 ||
        AF_LEVEL < 1 || AF_LEVEL > MEM_DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > MEM_DEPTH - 1) begin : g_param_err
        $error("sync_fifo_ram: illegal parameter combination");
    end

    logic [MEM_WIDTH-1:0]    mem [MEM_DEPTH];
    logic [ADDRESS_SIZE-1:0] w_ptr, r_ptr;
    logic [ADDRESS_SIZE:0]   count_next;
    logic                    wr_ok, rd_ok;

    // Acceptance uses the registered flags; flush masks both requests.
    assign wr_ok = w_en && !full  && !flush;
    assign rd_ok = r_en && !empty && !flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    // Array has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[w_ptr] <= w_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
        end else begin
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CNT_FULL);
            almost_empty <= (count_next <= CNT_AE);
            almost_full  <= (count_next >= CNT_AF);
            r_valid      <= rd_ok;
            if (flush) begin
                w_ptr <= '0;
                r_ptr <= '0;
            end else begin
                if (wr_ok) w_ptr <= (w_ptr == LAST_ADDR) ? '0 : w_ptr + PTR_ONE;
                if (rd_ok) begin
                    r_data <= mem[r_ptr];
                    r_ptr  <= (r_ptr == LAST_ADDR) ? '0 : r_ptr + PTR_ONE;
                end
            end
        end
    end

    // Errors are set by the raw requests against the registered flags; set beats clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!flush && w_en && full)       overflow <= 1'b1;
            else if (err_clr)                 overflow <= 1'b0;
            if (!flush && r_en && empty)      underflow <= 1'b1;
            else if (err_clr)                 underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Scoreboard bench for sync_fifo_ram: default 8-deep instance plus a 6-deep
// instance for non-power-of-two wrap.
module tb_sync_fifo_ram;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance (depth 8)
    logic        a_flush = 0, a_w_en = 0, a_r_en = 0, a_err_clr = 0;
    logic [31:0] a_w_data = '0, a_r_data;
    logic        a_r_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0]  a_count;

    sync_fifo_ram dut_a (
        .clk(clk), .resetn(resetn), .flush(a_flush), .w_en(a_w_en), .w_data(a_w_data),
        .r_en(a_r_en), .err_clr(a_err_clr), .r_data(a_r_data), .r_valid(a_r_valid),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    // Depth-6 instance
    logic        b_flush = 0, b_w_en = 0, b_r_en = 0, b_err_clr = 0;
    logic [31:0] b_w_data = '0, b_r_data;
    logic        b_r_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [3:0]  b_count;

    sync_fifo_ram #(.MEM_WIDTH(32), .MEM_DEPTH(6), .ADDRESS_SIZE(3), .AF_LEVEL(5), .AE_LEVEL(1)) dut_b (
        .clk(clk), .resetn(resetn), .flush(b_flush), .w_en(b_w_en), .w_data(b_w_data),
        .r_en(b_r_en), .err_clr(b_err_clr), .r_data(b_r_data), .r_valid(b_r_valid),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every r_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (resetn && a_r_valid) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_read actual=%0h required=none", a_r_data);
            end else begin
                logic [31:0] e;
                e = qa.pop_front();
                if (a_r_data !== e) begin
                    errors++;
                    $display("FAIL a_read_data actual=%0h required=%0h", a_r_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && b_r_valid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_read actual=%0h required=none", b_r_data);
            end else begin
                logic [31:0] e;
                e = qb.pop_front();
                if (b_r_data !== e) begin
                    errors++;
                    $display("FAIL b_read_data actual=%0h required=%0h", b_r_data, e);
                end
            end
        end
    end

    task automatic chk_reset_a(input string tag);
        chk({tag, "_count"}, a_count, 0);
        chk({tag, "_empty"}, a_empty, 1);
        chk({tag, "_full"}, a_full, 0);
        chk({tag, "_ae"}, a_ae, 1);
        chk({tag, "_af"}, a_af, 0);
        chk({tag, "_r_data"}, a_r_data, 0);
        chk({tag, "_r_valid"}, a_r_valid, 0);
        chk({tag, "_ovf"}, a_ovf, 0);
        chk({tag, "_unf"}, a_unf, 0);
    endtask

    // Hand-written almost_full expectation during fill (AF_LEVEL=6)
    logic [7:0] af_exp [8] = '{0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        #12;
        chk_reset_a("rst");
        resetn = 1'b1;
        tick();

        // Fill 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            a_w_en = 1; a_w_data = 32'((i + 1) * 'h11);
            tick();
            chk("fill_count", a_count, 64'(i + 1));
            chk("fill_af", a_af, 64'(af_exp[i]));
        end
        a_w_en = 0;
        chk("fill_full", a_full, 1);
        chk("fill_empty", a_empty, 0);

        // Full: write+read accepts read only
        a_w_en = 1; a_w_data = 32'h99; a_r_en = 1; qa.push_back(32'h11);
        tick();
        a_w_en = 0; a_r_en = 0;
        chk("ovf_count", a_count, 7);
        chk("ovf_flag", a_ovf, 1);
        chk("ovf_full", a_full, 0);
        a_err_clr = 1;
        tick();
        a_err_clr = 0;
        chk("ovf_clr", a_ovf, 0);

        // Drain the rest
        for (int i = 2; i <= 8; i++) begin
            a_r_en = 1; qa.push_back(32'(i * 'h11));
            tick();
        end
        a_r_en = 0;
        tick();
        chk("drain_empty", a_empty, 1);
        chk("drain_count", a_count, 0);
        chk("drain_r_valid", a_r_valid, 0);

        // Empty: write+read accepts write only
        a_w_en = 1; a_w_data = 32'hAB; a_r_en = 1;
        tick();
        a_w_en = 0; a_r_en = 0;
        chk("ewr_count", a_count, 1);
        chk("ewr_r_valid", a_r_valid, 0);
        chk("ewr_unf", a_unf, 1);
        a_r_en = 1; qa.push_back(32'hAB);
        tick();
        a_r_en = 0;
        tick();
        chk("ewr_empty", a_empty, 1);

        // err_clr alone clears; coinciding with a new error, set wins
        a_err_clr = 1;
        tick();
        chk("unf_clr", a_unf, 0);
        a_r_en = 1;
        tick();
        a_r_en = 0; a_err_clr = 0;
        chk("unf_set_wins", a_unf, 1);
        a_err_clr = 1;
        tick();
        a_err_clr = 0;

        // Flush with a concurrent write at count=5
        for (int i = 0; i < 5; i++) begin
            a_w_en = 1; a_w_data = 32'hC1 + 32'(i);
            tick();
        end
        a_w_en = 0;
        chk("pre_flush_count", a_count, 5);
        a_flush = 1; a_w_en = 1; a_w_data = 32'hEE;
        tick();
        a_flush = 0; a_w_en = 0;
        chk("flush_count", a_count, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_ae", a_ae, 1);
        chk("flush_r_valid", a_r_valid, 0);
        chk("flush_r_data", a_r_data, 32'hAB);
        a_w_en = 1; a_w_data = 32'h5A;
        tick();
        a_w_en = 0; a_r_en = 1; qa.push_back(32'h5A);
        tick();
        a_r_en = 0;

        // Async reset between edges at count=4
        for (int i = 0; i < 4; i++) begin
            a_w_en = 1; a_w_data = 32'hD1 + 32'(i);
            tick();
        end
        a_w_en = 0;
        chk("pre_rst_count", a_count, 4);
        #3;
        resetn = 1'b0;
        #1;
        chk_reset_a("midrst");
        #3;
        resetn = 1'b1;
        tick();
        a_w_en = 1; a_w_data = 32'hE7;
        tick();
        a_w_en = 0; a_r_en = 1; qa.push_back(32'hE7);
        tick();
        a_r_en = 0;
        tick();

        // Depth-6 wrap: prefill 4, then 16 write+read pairs, then drain
        for (int k = 1; k <= 4; k++) begin
            b_w_en = 1; b_w_data = 32'h30 + 32'(k);
            tick();
        end
        for (int k = 5; k <= 20; k++) begin
            b_w_en = 1; b_w_data = 32'h30 + 32'(k);
            b_r_en = 1; qb.push_back(32'h30 + 32'(k - 4));
            tick();
            chk("wrap_count", b_count, 4);
        end
        b_w_en = 0;
        for (int k = 17; k <= 20; k++) begin
            b_r_en = 1; qb.push_back(32'h30 + 32'(k));
            tick();
        end
        b_r_en = 0;
        tick();
        chk("wrap_empty", b_empty, 1);
        chk("wrap_ovf", b_ovf, 0);

        tick();
        chk("qa_drained", 64'(qa.size()), 0);
        chk("qb_drained", 64'(qb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
